// File: rtl/jump_resolve_unit_pkg.sv
// Shared encodings for the jump/branch resolve unit: op types and FSM states.
package jump_defs;

  localparam logic [1:0] OP_BR   = 2'b00;
  localparam logic [1:0] OP_JAL  = 2'b01;
  localparam logic [1:0] OP_JALR = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // The reserved encoding 11 resolves as a branch, so only JAL/JALR count as jumps.
  function automatic logic is_jump(input logic [1:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/jump_resolve_unit_stat.sv
// Resolution statistics counters; built only when JRU_STATS_EN is defined.
module jru_stat_counters
  import jump_defs::*;
#(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resolve,
  input  logic              is_branch,
  input  logic              taken,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_redirects
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches  <= '0;
      stat_taken     <= '0;
      stat_redirects <= '0;
    end else if (resolve) begin
      if (is_branch)          stat_branches  <= stat_branches + STAT_W'(1);
      if (is_branch && taken) stat_taken     <= stat_taken + STAT_W'(1);
      if (taken)              stat_redirects <= stat_redirects + STAT_W'(1);
    end
  end

endmodule

// File: rtl/jump_resolve_unit.sv
// Tracks one in-flight JAL/JALR/branch op, redirects fetch when taken and returns the link value.
// Optional JRU_STATS_EN adds resolution statistics counters.
module jump_resolve_unit
  import jump_defs::*;
#(
  parameter int XLEN   = 32,
  parameter int RW     = 5,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [1:0]        issue_op,
  input  logic [RW-1:0]     issue_rd,
  output logic              busy,
  input  logic              fu_done,
  input  logic              fu_cmp_res,
  input  logic [XLEN-1:0]   fu_pc_jump,
  input  logic [XLEN-1:0]   fu_pc_wb,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush,
  output logic              wb_valid,
  output logic [RW-1:0]     wb_rd,
  output logic [XLEN-1:0]   wb_data,
`ifdef JRU_STATS_EN
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_redirects,
`endif
  input  logic              wb_ready
);

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [RW-1:0] rd_q;
  logic          resolve, jump, taken;

  assign busy    = (state != S_IDLE);
  assign resolve = (state == S_EXEC) && fu_done;
  assign jump    = is_jump(op_q);
  // Static not-taken prediction: any taken outcome is a mispredict.
  assign taken   = jump || fu_cmp_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= OP_BR;
      rd_q           <= '0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      case (state)
        S_IDLE: if (issue_en) begin
          op_q  <= issue_op;
          rd_q  <= issue_rd;
          state <= S_EXEC;
        end
        S_EXEC: if (fu_done) begin
          if (taken) begin
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            redirect_pc    <= fu_pc_jump & ~XLEN'(1);
          end
          if (jump && rd_q != '0) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= fu_pc_wb;
            state    <= S_WB;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WB: if (wb_ready) begin
          wb_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JRU_STATS_EN
  jru_stat_counters #(.STAT_W(STAT_W)) u_stats (
    .clk            (clk),
    .rst            (rst),
    .resolve        (resolve),
    .is_branch      (!jump),
    .taken          (taken),
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken),
    .stat_redirects (stat_redirects)
  );
`endif

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Scoreboard bench for jump_resolve_unit: redirects and wb handshakes are predicted at fu_done and popped when seen.
module tb_jump_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, issue_en, fu_done, fu_cmp_res, wb_ready;
  logic [1:0]  issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] fu_pc_jump, fu_pc_wb;
  logic        busy, redirect_valid, flush, wb_valid;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0]  wb_rd;
`ifdef JRU_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_redirects;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] redir_q[$];
  logic [36:0] wb_q[$];
  logic [1:0]  cur_op;
  logic [4:0]  cur_rd;
  int          m_br = 0, m_tk = 0, m_rd = 0;

  always #5 clk = ~clk;

  jump_resolve_unit dut (
    .clk(clk), .rst(rst), .issue_en(issue_en), .issue_op(issue_op), .issue_rd(issue_rd),
    .busy(busy), .fu_done(fu_done), .fu_cmp_res(fu_cmp_res), .fu_pc_jump(fu_pc_jump),
    .fu_pc_wb(fu_pc_wb), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef JRU_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_redirects(stat_redirects),
`endif
    .wb_ready(wb_ready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] rd);
    issue_en = 1'b1; issue_op = op; issue_rd = rd;
    cur_op = op; cur_rd = rd;
    tick();
    issue_en = 1'b0;
  endtask

  // Drives one fu_done cycle and predicts what the unit must emit.
  task automatic fu(input logic cmp, input logic [31:0] pj, input logic [31:0] pw);
    logic jmp, tk;
    jmp = (cur_op == 2'b01) || (cur_op == 2'b10);
    tk  = jmp || cmp;
    if (tk) begin
      redir_q.push_back({pj[31:1], 1'b0});
      m_rd++;
    end
    if (!jmp) begin
      m_br++;
      if (cmp) m_tk++;
    end
    if (jmp && cur_rd != 5'd0) wb_q.push_back({cur_rd, pw});
    fu_done = 1'b1; fu_cmp_res = cmp; fu_pc_jump = pj; fu_pc_wb = pw;
    tick();
    fu_done = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".busy"},   busy, 0);
    chk({tag, ".redir"},  redirect_valid, 0);
    chk({tag, ".flush"},  flush, 0);
    chk({tag, ".wbv"},    wb_valid, 0);
    chk({tag, ".pc"},     redirect_pc, 0);
    chk({tag, ".wbrd"},   wb_rd, 0);
    chk({tag, ".wbdata"}, wb_data, 0);
  endtask

  // Monitor: every observed redirect / wb handshake must match the head of its queue.
  always @(negedge clk) begin
    if (redirect_valid || flush) begin
      chk("flush_eq_redir", flush, redirect_valid);
      if (redir_q.size() == 0) chk("unexpected_redirect", redirect_pc, 0);
      else chk("redirect_pc", redirect_pc, redir_q.pop_front());
    end
    if (wb_valid && wb_ready) begin
      if (wb_q.size() == 0) chk("unexpected_wb", {wb_rd, wb_data}, 0);
      else chk("wb", {wb_rd, wb_data}, wb_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; issue_en = 0; issue_op = 0; issue_rd = 0;
    fu_done = 0; fu_cmp_res = 0; fu_pc_jump = 0; fu_pc_wb = 0; wb_ready = 0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk); chk_reset_outs("reset");
    tick();

    // 1: taken branch
    issue(2'b00, 5'd5);
    @(negedge clk); chk("c1.busy_exec", busy, 1);
    tick();
    fu(1'b1, 32'h140, 32'h99);
    @(negedge clk); chk("c1.wbv", wb_valid, 0); chk("c1.busy", busy, 0);
    tick();
    @(negedge clk); chk("c1.pulse_end", redirect_valid, 0); chk("c1.pc_hold", redirect_pc, 32'h140);

    // 2: not-taken branch, immediate re-issue of 3
    tick();
    issue(2'b00, 5'd3);
    fu(1'b0, 32'h140, 32'h0);
    @(negedge clk); chk("c2.busy", busy, 0); chk("c2.redir", redirect_valid, 0);

    // 3: JAL rd=1, wb_ready held low 3 cycles
    issue(2'b01, 5'd1);
    wb_ready = 1'b0;
    fu(1'b0, 32'h200, 32'h104);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin wb_ready = 1'b1; #1; end
      @(negedge clk);
      chk("c3.wbv", wb_valid, 1); chk("c3.rd", wb_rd, 1); chk("c3.data", wb_data, 32'h104);
      tick();
    end
    wb_ready = 1'b0;
    @(negedge clk); chk("c3.wb_done", wb_valid, 0); chk("c3.busy", busy, 0);

    // 4: JALR rd=0, odd target
    issue(2'b10, 5'd0);
    fu(1'b0, 32'h301, 32'h55);
    @(negedge clk); chk("c4.wbv", wb_valid, 0); chk("c4.busy", busy, 0);
    tick();

`ifdef JRU_STATS_EN
    chk("stat_branches", stat_branches, 2);
    chk("stat_taken", stat_taken, 1);
    chk("stat_redirects", stat_redirects, 3);
    chk("stat_model", {stat_branches, stat_taken}, {32'(m_br), 32'(m_tk)});
`endif

    // 6: issue while busy must not disturb the held branch; fu_done in IDLE ignored
    issue(2'b00, 5'd7);
    issue_en = 1'b1; issue_op = 2'b01; issue_rd = 5'd9;
    tick();
    issue_en = 1'b0;
    @(negedge clk); chk("c6.busy", busy, 1);
    fu(1'b1, 32'h400, 32'h77);
    @(negedge clk); chk("c6.wbv", wb_valid, 0);
    tick();
    fu_done = 1'b1; fu_cmp_res = 1'b1; fu_pc_jump = 32'h480;
    tick(); tick();
    fu_done = 1'b0;
    @(negedge clk); chk("c6.idle_busy", busy, 0); chk("c6.idle_pc", redirect_pc, 32'h400);

    // 5a: reset during WB drops the pending writeback
    issue(2'b01, 5'd4);
    redir_q.push_back(32'h500); m_rd++;
    fu_done = 1'b1; fu_cmp_res = 1'b0; fu_pc_jump = 32'h500; fu_pc_wb = 32'h108;
    tick();
    fu_done = 1'b0;
    @(negedge clk); chk("c5.in_wb", wb_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk); chk_reset_outs("c5a");
    fu_done = 1'b1; tick(); fu_done = 1'b0;
    @(negedge clk); chk("c5.late_fu", redirect_valid, 0);

    // 5b: reset coincident with fu_done in EXEC wins
    issue(2'b00, 5'd2);
    rst = 1'b1; fu_done = 1'b1; fu_cmp_res = 1'b1; fu_pc_jump = 32'h700;
    tick();
    rst = 1'b0; fu_done = 1'b0;
    @(negedge clk); chk_reset_outs("c5b");

    // fresh issue after reset, ready already high
    tick();
    wb_ready = 1'b1;
    issue(2'b01, 5'd6);
    fu(1'b0, 32'h600, 32'h10c);
    tick(); tick();
    @(negedge clk); chk("c5.fresh_busy", busy, 0);

    chk("redir_q_empty", redir_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
